// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and writeback.
// Issues loads/stores on a req/ack port, stalls execute while an access is
// outstanding and registers results for writeback.
// Ports: clk_i/rst_i (sync, active-high); execute side valid_i, wreg_i,
// m2reg_i, wmem_i, destination_i, aluresult_i, op2_i, stall_o; memory side
// mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_ack_i, mem_rdata_i;
// writeback side valid_o, wreg_o, m2reg_o, destination_o, aluresult_o,
// memdata_o, err_o.
// Optional macro MEM_TIMEOUT_EN: abort an access after TimeoutCycles
// unacknowledged WAIT cycles and pulse err_o; otherwise err_o is tied 0.

`ifndef BITS_REGFILE
`define BITS_REGFILE 5
`endif

module mem_stage #(
  parameter int DataWidth     = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   valid_i,
  input  logic                   wreg_i,
  input  logic                   m2reg_i,
  input  logic                   wmem_i,
  input  logic [`BITS_REGFILE:0] destination_i,
  input  logic [DataWidth-1:0]   aluresult_i,
  input  logic [DataWidth-1:0]   op2_i,
  output logic                   stall_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [DataWidth-1:0]   mem_addr_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  input  logic                   mem_ack_i,
  input  logic [DataWidth-1:0]   mem_rdata_i,
  output logic                   valid_o,
  output logic                   wreg_o,
  output logic                   m2reg_o,
  output logic [`BITS_REGFILE:0] destination_o,
  output logic [DataWidth-1:0]   aluresult_o,
  output logic [DataWidth-1:0]   memdata_o,
  output logic                   err_o
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state;
  state_t state_nx;

  logic                   l_wreg;
  logic                   l_m2reg;
  logic                   l_wmem;
  logic [`BITS_REGFILE:0] l_dest;
  logic [DataWidth-1:0]   l_alu;
  logic [DataWidth-1:0]   l_op2;

  logic in_idle;
  logic in_wait;
  logic is_mem;
  logic accept;
  logic timeout;

  assign in_idle = (state == S_IDLE);
  assign in_wait = (state == S_WAIT);
  assign is_mem  = m2reg_i | wmem_i;
  assign accept  = in_idle & valid_i & is_mem;

`ifdef MEM_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles);

  logic [CntW-1:0] cnt;
  logic            err_q;

  // Held at zero outside WAIT, so it is clear on every WAIT entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || in_idle) begin
      cnt <= '0;
    end else if (!mem_ack_i) begin
      cnt <= cnt + 1'b1;
    end
  end

  // An ack in the last allowed cycle completes normally.
  assign timeout = in_wait & ~mem_ack_i &
                   (cnt == CntW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= timeout;
    end
  end

  assign err_o = err_q;
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: if (accept) state_nx = S_WAIT;
      S_WAIT: if (mem_ack_i || timeout) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    mem_req_o   = in_wait;
    mem_we_o    = in_wait & l_wmem;
    mem_addr_o  = in_wait ? l_alu : '0;
    mem_wdata_o = (in_wait & l_wmem) ? l_op2 : '0;
    stall_o     = in_wait & ~mem_ack_i;
  end

  // A store wins over a load when both flags are set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      l_wreg  <= 1'b0;
      l_m2reg <= 1'b0;
      l_wmem  <= 1'b0;
      l_dest  <= '0;
      l_alu   <= '0;
      l_op2   <= '0;
    end else if (accept) begin
      l_wreg  <= wreg_i;
      l_m2reg <= m2reg_i & ~wmem_i;
      l_wmem  <= wmem_i;
      l_dest  <= destination_i;
      l_alu   <= aluresult_i;
      l_op2   <= op2_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o       <= 1'b0;
      wreg_o        <= 1'b0;
      m2reg_o       <= 1'b0;
      destination_o <= '0;
      aluresult_o   <= '0;
      memdata_o     <= '0;
    end else begin
      unique case (1'b1)
        in_idle & valid_i & ~is_mem: begin
          valid_o       <= 1'b1;
          wreg_o        <= wreg_i;
          m2reg_o       <= 1'b0;
          destination_o <= destination_i;
          aluresult_o   <= aluresult_i;
        end
        in_wait & mem_ack_i: begin
          valid_o       <= 1'b1;
          wreg_o        <= l_wreg;
          m2reg_o       <= l_m2reg;
          destination_o <= l_dest;
          aluresult_o   <= l_alu;
          memdata_o     <= l_m2reg ? mem_rdata_i : '0;
        end
        timeout: begin
          // Aborted access retires as a no-op.
          valid_o       <= 1'b1;
          wreg_o        <= 1'b0;
          m2reg_o       <= 1'b0;
          destination_o <= l_dest;
          aluresult_o   <= l_alu;
          memdata_o     <= '0;
        end
        default: begin
          valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage.
- Consumes execute results (wreg, m2reg, wmem, destination, aluresult, op2) and performs loads/stores over a req/ack data-memory port.
- Registers the results for writeback and stalls upstream while a memory access is outstanding.

Parameters:
- DataWidth, 32, width of aluresult, op2, memory data and address.
- TimeoutCycles, 16, WAIT cycles before an access is aborted (used only with MEM_TIMEOUT_EN).

Ports:
- clk_i  in  1  clock, single domain
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  execute output holds a valid instruction
- wreg_i  in  1  instruction writes register file
- m2reg_i  in  1  load: writeback data comes from memory
- wmem_i  in  1  store
- destination_i  in  `BITS_REGFILE+1  destination register index
- aluresult_i  in  DataWidth  ALU result / memory address
- op2_i  in  DataWidth  store data
- stall_o  out  1  hold execute stage inputs
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write enable
- mem_addr_o  out  DataWidth  memory address
- mem_wdata_o  out  DataWidth  store data
- mem_ack_i  in  1  request accepted/completed; rdata valid the same cycle
- mem_rdata_i  in  DataWidth  load data
- valid_o  out  1  writeback-side valid
- wreg_o  out  1  registered wreg
- m2reg_o  out  1  registered m2reg
- destination_o  out  `BITS_REGFILE+1  registered destination
- aluresult_o  out  DataWidth  registered ALU result
- memdata_o  out  DataWidth  captured load data
- err_o  out  1  access aborted (MEM_TIMEOUT_EN only)

Behaviour:
- Reset: state IDLE; all outputs 0, including stall_o, mem_req_o, valid_o and err_o.
- FSM states:
  - IDLE
  - WAIT (request outstanding)
- IDLE, valid_i=1, m2reg_i=0, wmem_i=0:
  - Inputs are registered to the outputs at the next edge, giving valid_o=1 with 1-cycle latency.
  - memdata_o holds its previous value.
- IDLE, valid_i=1, m2reg_i|wmem_i:
  - Latch the instruction fields and go to WAIT.
  - From the next cycle: mem_req_o=1, mem_we_o=wmem, mem_addr_o=latched aluresult, mem_wdata_o=latched op2 (0 when not a store).
  - valid_o=0 next cycle.
- m2reg_i and wmem_i both set: treated as a store; m2reg_o forced 0.
- IDLE, valid_i=0: valid_o=0 next cycle; other outputs hold.
- WAIT:
  - stall_o = ~mem_ack_i (combinational).
  - mem_req_o and address/data are held stable until ack.
  - Stage inputs are ignored.
- WAIT, mem_ack_i=1:
  - Next edge: state IDLE, mem_req_o=0, valid_o=1, outputs loaded from latched fields.
  - memdata_o = mem_rdata_i for a load, 0 for a store.
  - Upstream advances in the ack cycle because stall_o is already 0.
- Ack in the same cycle as the request (first WAIT cycle): legal; minimum load/store latency is 2 cycles from valid_i.
- mem_ack_i outside WAIT: ignored.
- Reset mid-access: next edge forces IDLE, drops mem_req_o and clears outputs; the access is not retried.
- Back-to-back memory operations: the next op is accepted in IDLE the cycle after return, so mem_req_o has at least one idle cycle between requests.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- With the macro defined:
  - A $clog2(TimeoutCycles)-bit counter clears on entering WAIT and increments each WAIT cycle without ack.
  - On reaching TimeoutCycles-1 with no ack: next edge goes to IDLE, mem_req_o=0, err_o=1 for exactly 1 cycle.
  - The instruction is killed: valid_o=1, wreg_o=0, memdata_o=0.
  - An ack in the timeout cycle wins (normal completion, err_o=0).
- Without the macro: WAIT lasts indefinitely, err_o is tied 0, and the counter is absent.

Test Plan:
- Reset: rst_i=1 for 2 cycles with valid_i=1 -> all outputs 0, stall_o=0.
- ALU op: valid_i=1, wreg_i=1, destination_i=5, aluresult_i=0x1234 -> next cycle valid_o=1, wreg_o=1, destination_o=5, aluresult_o=0x1234; mem_req_o stays 0.
- Load with 3-cycle ack delay: m2reg_i=1, aluresult_i=0x40, rdata=0xDEADBEEF -> mem_req_o=1, mem_addr_o=0x40, stall_o=1 for 2 cycles then 0 in the ack cycle; next cycle memdata_o=0xDEADBEEF, m2reg_o=1, valid_o=1.
- Store with immediate ack: wmem_i=1, aluresult_i=0x80, op2_i=0xA5A5 -> one cycle with mem_we_o=1, mem_wdata_o=0xA5A5; valid_o=1, memdata_o=0 next cycle; total latency 2.
- Reset asserted in the 2nd WAIT cycle of a load -> mem_req_o=0 and valid_o=0 after the edge; a late ack is ignored.
- MEM_TIMEOUT_EN, TimeoutCycles=4, no ack -> mem_req_o high for 4 cycles; err_o pulses 1 cycle with valid_o=1, wreg_o=0; FSM back in IDLE.
